// File: rtl/gpio_side_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_side_ctrl
//
// Register-mapped controller for the GPIO pads along one side of the
// padring. A simple valid/ready request channel reads and writes a small
// word-addressed register file. A one-entry response buffer returns read
// data, or zero for writes. The OUT/OEN/IE registers drive the pad buses
// straight from flops. Pad input data is synchronised before it is read
// back.
//
// Register map (word addresses):
//   0 OUT     rw  pad output data
//   1 OEN     rw  output enable, 1 = driver off
//   2 IE      rw  input enable, gates IN
//   3 IN      ro  synchronised pad_din AND IE
//   4 IRQEN   rw  interrupt enable (interrupt build only)
//   5 IRQSTAT w1c rising-edge status (interrupt build only)
//   6-7       reads 0, writes ignored
//
// Optional feature: define GPIO_SIDE_IRQ_EN to build the rising-edge
// interrupt logic (IRQEN, IRQSTAT, irq). Without it those registers read as
// zero, ignore writes, and irq is tied low.
//
// Ports:
//   clk        sole clock, all state on the rising edge
//   nreset     asynchronous active-low reset
//   req_valid  request valid
//   req_ready  request accepted when req_valid && req_ready
//   req_write  1 = write, 0 = read
//   req_addr   register word address (AW bits)
//   req_wdata  write data (NPINS bits)
//   rsp_valid  response valid
//   rsp_ready  response consumed when rsp_valid && rsp_ready
//   rsp_rdata  read data, 0 for writes
//   pad_din    asynchronous pad input data
//   pad_dout   pad output data bus
//   pad_oen    pad output-enable bus (1 = driver off)
//   pad_ie     pad input-enable bus
//   irq        level interrupt
// ---------------------------------------------------------------------------
module gpio_side_ctrl #(
    parameter int NPINS = 9,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [NPINS-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [NPINS-1:0] rsp_rdata,
    input  logic [NPINS-1:0] pad_din,
    output logic [NPINS-1:0] pad_dout,
    output logic [NPINS-1:0] pad_oen,
    output logic [NPINS-1:0] pad_ie,
    output logic             irq
);

    localparam logic [AW-1:0] A_OUT     = AW'(0);
    localparam logic [AW-1:0] A_OEN     = AW'(1);
    localparam logic [AW-1:0] A_IE      = AW'(2);
    localparam logic [AW-1:0] A_IN      = AW'(3);
    localparam logic [AW-1:0] A_IRQEN   = AW'(4);
    localparam logic [AW-1:0] A_IRQSTAT = AW'(5);

    logic [NPINS-1:0] out_q;
    logic [NPINS-1:0] oen_q;
    logic [NPINS-1:0] ie_q;
    logic [NPINS-1:0] din_p0;
    logic [NPINS-1:0] din_p1;
    logic [NPINS-1:0] in_val;
    logic [NPINS-1:0] irqen_val;
    logic [NPINS-1:0] irqstat_val;
    logic [NPINS-1:0] rdata_mux;
    logic             rsp_valid_q;
    logic [NPINS-1:0] rsp_rdata_q;
    logic             accept;
    logic             wr_acc;

    // The buffer is one entry deep: a new request can be taken whenever the
    // slot is empty or is being drained in this same cycle.
    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign wr_acc    = accept && req_write;

    // ---- Stage p0/p1: two-flop synchroniser on the asynchronous pad inputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            din_p0 <= '0;
            din_p1 <= '0;
        end else begin
            din_p0 <= pad_din;
            din_p1 <= din_p0;
        end
    end

    assign in_val = din_p1 & ie_q;

    // ---- Pad control registers, driven straight onto the pad buses
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_q <= '0;
            oen_q <= '1;
            ie_q  <= '1;
        end else if (wr_acc) begin
            if (req_addr == A_OUT) out_q <= req_wdata;
            if (req_addr == A_OEN) oen_q <= req_wdata;
            if (req_addr == A_IE)  ie_q  <= req_wdata;
        end
    end

    assign pad_dout = out_q;
    assign pad_oen  = oen_q;
    assign pad_ie   = ie_q;

`ifdef GPIO_SIDE_IRQ_EN
    logic [NPINS-1:0] irqen_q;
    logic [NPINS-1:0] irqstat_q;
    logic [NPINS-1:0] in_prev_q;
    logic [NPINS-1:0] rise;
    logic [NPINS-1:0] stat_clr;
    logic             irq_q;

    assign rise     = in_val & ~in_prev_q;
    assign stat_clr = (wr_acc && req_addr == A_IRQSTAT) ? req_wdata : '0;

    // ---- Edge detect, status and registered interrupt output
    // The set term is OR-ed in after the clear, so an edge that lands in
    // the same cycle as a W1C of that bit keeps the bit set.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            irqen_q   <= '0;
            irqstat_q <= '0;
            in_prev_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_acc && req_addr == A_IRQEN) irqen_q <= req_wdata;
            irqstat_q <= (irqstat_q & ~stat_clr) | rise;
            in_prev_q <= in_val;
            irq_q     <= |(irqstat_q & irqen_q);
        end
    end

    assign irqen_val   = irqen_q;
    assign irqstat_val = irqstat_q;
    assign irq         = irq_q;
`else
    assign irqen_val   = '0;
    assign irqstat_val = '0;
    assign irq         = 1'b0;
`endif

    // Read data reflects the register values before this cycle's update, so
    // a read of IRQSTAT never sees a set or clear that is happening now.
    always_comb begin
        rdata_mux = '0;
        case (req_addr)
            A_OUT:     rdata_mux = out_q;
            A_OEN:     rdata_mux = oen_q;
            A_IE:      rdata_mux = ie_q;
            A_IN:      rdata_mux = in_val;
            A_IRQEN:   rdata_mux = irqen_val;
            A_IRQSTAT: rdata_mux = irqstat_val;
            default:   rdata_mux = '0;
        endcase
    end

    // ---- Response buffer: loads on acceptance, otherwise holds until consumed
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= req_write ? '0 : rdata_mux;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gpio_side_ctrl.sv
// Testbench for gpio_side_ctrl: directed scenarios plus random traffic.
// A transaction-level model predicts each response, and a separate monitor
// compares what the DUT returns. Pad buses, irq and handshake signals are
// compared every cycle against the same model.
module tb_gpio_side_ctrl;

    localparam int NP = 9;
    localparam int AW = 3;
`ifdef GPIO_SIDE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [NP-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic [NP-1:0] pad_din = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [NP-1:0] rsp_rdata;
    logic [NP-1:0] pad_dout;
    logic [NP-1:0] pad_oen;
    logic [NP-1:0] pad_ie;
    logic          irq;

    gpio_side_ctrl #(.NPINS(NP), .AW(AW)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .pad_din   (pad_din),
        .pad_dout  (pad_dout),
        .pad_oen   (pad_oen),
        .pad_ie    (pad_ie),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [NP-1:0] exp_q[$];

    // Reference model: register file by address, pending-response flag,
    // pad history for the two-cycle synchroniser delay, last IN value.
    logic [NP-1:0] m_reg [0:7];
    logic          m_rvld;
    logic          m_irq;
    logic [NP-1:0] m_inprev;
    logic [NP-1:0] pad_m1;
    logic [NP-1:0] pad_m2;

    task automatic check(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_reg[1] = '1;
        m_reg[2] = '1;
        m_rvld   = 1'b0;
        m_irq    = 1'b0;
        m_inprev = '0;
        pad_m1   = '0;
        pad_m2   = '0;
    endtask

    function automatic logic [NP-1:0] model_read(input logic [AW-1:0] a, input logic [NP-1:0] in_now);
        case (a)
            3'd0, 3'd1, 3'd2: return m_reg[a];
            3'd3:             return in_now;
            3'd4, 3'd5:       return IRQ_ON ? m_reg[a] : '0;
            default:          return '0;
        endcase
    endfunction

    // One clock cycle: drive inputs after the edge, check and advance the
    // model at the falling edge.
    task automatic cyc(input bit v, input bit w, input logic [AW-1:0] a,
                       input logic [NP-1:0] d, input bit rr, input logic [NP-1:0] pad,
                       output bit acc);
        logic [NP-1:0] in_now, rise, stat_n;
        logic irq_n;
        @(posedge clk);
        #1;
        req_valid = v; req_write = w; req_addr = a; req_wdata = d;
        rsp_ready = rr; pad_din = pad;
        @(negedge clk);
        in_now = pad_m2 & m_reg[2];
        check("pad_dout",  pad_dout,  m_reg[0]);
        check("pad_oen",   pad_oen,   m_reg[1]);
        check("pad_ie",    pad_ie,    m_reg[2]);
        check("irq",       NP'(irq),  NP'(m_irq));
        check("rsp_valid", NP'(rsp_valid), NP'(m_rvld));
        check("req_ready", NP'(req_ready), NP'(!m_rvld || rr));
        acc = v && (!m_rvld || rr);
        if (acc) exp_q.push_back(w ? '0 : model_read(a, in_now));
        rise   = IRQ_ON ? (in_now & ~m_inprev) : '0;
        irq_n  = IRQ_ON && (|(m_reg[5] & m_reg[4]));
        stat_n = m_reg[5];
        if (acc && w) begin
            case (a)
                3'd0, 3'd1, 3'd2: m_reg[a] = d;
                3'd4:             if (IRQ_ON) m_reg[4] = d;
                3'd5:             stat_n = stat_n & ~d;
                default: ;
            endcase
        end
        m_reg[5] = IRQ_ON ? (stat_n | rise) : '0;
        m_irq    = irq_n;
        m_rvld   = acc ? 1'b1 : (rr ? 1'b0 : m_rvld);
        m_inprev = in_now;
        pad_m2   = pad_m1;
        pad_m1   = pad;
    endtask

    // Assert reset in the middle of a cycle, check the immediate effect,
    // then release it with the bus idle and pads low.
    task automatic reset_mid();
        @(posedge clk);
        #2;
        nreset = 1'b0;
        req_valid = 1'b0;
        pad_din = '0;
        exp_q.delete();
        model_reset();
        #1;
        check("rst_rsp_valid", NP'(rsp_valid), '0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_pad_oen",   pad_oen,   '1);
        check("rst_pad_dout",  pad_dout,  '0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("ready_after_rst", NP'(req_ready), NP'(1));
        check("no_rsp_after_rst", NP'(rsp_valid), '0);
    endtask

    // Monitor: compares each presented response against the queue head and
    // retires it on the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (nreset && rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_rsp: got rdata 0x%0h, expected no response at %0t", rsp_rdata, $time);
                end else begin
                    check("rsp_rdata", rsp_rdata, exp_q[0]);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        logic [NP-1:0] cur_pad;
        int stall;
        model_reset();
        // Reset values while held in reset
        repeat (2) @(negedge clk);
        check("rst_oen",   pad_oen,   '1);
        check("rst_ie",    pad_ie,    '1);
        check("rst_dout",  pad_dout,  '0);
        check("rst_rvld",  NP'(rsp_valid), '0);
        check("rst_irq",   NP'(irq),  '0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        check("first_ready", NP'(req_ready), NP'(1));

        // Read OEN after reset, then write OUT
        cyc(1, 0, 3'd1, '0, 1, '0, acc);
        cyc(1, 1, 3'd0, 9'h0A5, 1, '0, acc);
        cyc(0, 0, 3'd0, '0, 1, '0, acc);
        check("dout_a5", pad_dout, 9'h0A5);

        // Back-pressure: read held in the buffer, second request stalls
        cyc(1, 0, 3'd0, '0, 0, '0, acc);
        stall = 0;
        do begin
            cyc(1, 1, 3'd1, 9'h055, (stall >= 3), '0, acc);
            stall++;
        end while (!acc && stall < 10);
        check("stall_accepted", NP'(acc), NP'(1));
        cyc(0, 0, 3'd0, '0, 1, '0, acc);

        // IN follows synchronised pads gated by IE
        cyc(1, 1, 3'd2, 9'h001, 1, 9'h003, acc);
        repeat (3) cyc(0, 0, 3'd0, '0, 1, 9'h003, acc);
        cyc(1, 0, 3'd3, '0, 1, 9'h003, acc);
        cyc(1, 1, 3'd2, 9'h000, 1, 9'h003, acc);
        cyc(1, 0, 3'd3, '0, 1, 9'h003, acc);

        // Interrupt path: enable bit 2, rising edge, coincident W1C, plain W1C
        cyc(1, 1, 3'd2, 9'h1FF, 1, 9'h000, acc);
        cyc(1, 1, 3'd4, 9'h004, 1, 9'h000, acc);
        repeat (2) cyc(0, 0, 3'd0, '0, 1, 9'h000, acc);
        repeat (4) cyc(0, 0, 3'd0, '0, 1, 9'h004, acc);
        cyc(1, 0, 3'd5, '0, 1, 9'h004, acc);
        repeat (3) cyc(0, 0, 3'd0, '0, 1, 9'h000, acc);
        cyc(0, 0, 3'd0, '0, 1, 9'h004, acc);
        cyc(0, 0, 3'd0, '0, 1, 9'h004, acc);
        cyc(1, 1, 3'd5, 9'h004, 1, 9'h004, acc);
        repeat (2) cyc(1, 0, 3'd5, '0, 1, 9'h004, acc);
        cyc(1, 1, 3'd5, 9'h004, 1, 9'h004, acc);
        repeat (3) cyc(1, 0, 3'd5, '0, 1, 9'h004, acc);

        // Random traffic
        cur_pad = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) cur_pad = NP'($urandom);
            cyc(($urandom_range(0, 9) < 6), $urandom_range(0, 1), AW'($urandom_range(0, 7)),
                NP'($urandom), ($urandom_range(0, 9) < 7), cur_pad, acc);
        end

        // Reset while a response is pending
        cyc(1, 0, 3'd1, '0, 0, '0, acc);
        reset_mid();
        repeat (4) cyc(0, 0, 3'd0, '0, 1, '0, acc);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cur_pad = NP'($urandom);
            cyc(($urandom_range(0, 9) < 6), $urandom_range(0, 1), AW'($urandom_range(0, 7)),
                NP'($urandom), ($urandom_range(0, 9) < 7), cur_pad, acc);
        end

        repeat (4) cyc(0, 0, 3'd0, '0, 1, cur_pad, acc);
        check("queue_drained", NP'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
